// File: rtl/digest_seq_pkg.sv
// Shared types and constants for the digest word sequencer.
// Word 0 is H0, which sits in the top 32 bits of the 160-bit digest.
package digest_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    localparam int NUM_WORDS = 5;
    localparam int WORD_W    = 32;
    localparam int SEL_W     = 3;
    localparam int IDX_W     = 3;
    localparam int DIGEST_W  = NUM_WORDS * WORD_W;

    function automatic logic [WORD_W-1:0] digest_word(
        input logic [DIGEST_W-1:0] digest,
        input logic [IDX_W-1:0]    idx
    );
        logic [WORD_W-1:0] word;
        word = '0;
        case (idx)
            3'd0:    word = digest[159:128];
            3'd1:    word = digest[127:96];
            3'd2:    word = digest[95:64];
            3'd3:    word = digest[63:32];
            3'd4:    word = digest[31:0];
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Terminal-count counter: counts enabled cycles and emits a one-cycle tick
// on the cycle where the count sits at CYCLES-1, then rolls over to 0.
module tick_gen #(
    parameter int CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The tick must not depend on i_clr: the parent derives its clear from it.
    assign o_tick = i_en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digest_word_sequencer.sv
// Captures a SHA-1 digest and presents its five words one at a time,
// stepping manually or on a dwell timer, while sweeping a 3-bit scan select.
module digest_word_sequencer
    import digest_seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000000,
    parameter int SCAN_CYCLES  = 100000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_digest_valid,
    output logic                o_digest_ready,
    input  logic [DIGEST_W-1:0] i_digest,
    input  logic                i_step,
    input  logic                i_auto,
    output logic [WORD_W-1:0]   o_word,
    output logic [SEL_W-1:0]    o_select,
    output logic [IDX_W-1:0]    o_word_idx,
    output logic                o_busy,
    output logic                o_wrap
);

    state_e                state_q,  state_d;
    logic [DIGEST_W-1:0]   digest_q, digest_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [WORD_W-1:0]     word_q,   word_d;
    logic [SEL_W-1:0]      select_q, select_d;
    logic                  wrap_q,   wrap_d;
    logic                  busy_q,   busy_d;
    logic                  ready_q,  ready_d;

    logic show;
    logic capture;
    logic advance;
    logic dwell_tick;
    logic scan_tick;

    assign show    = (state_q == SHOW);
    assign capture = i_digest_valid && ready_q;
    // A capture wins over any simultaneous step or dwell tick.
    assign advance = show && (i_step || dwell_tick) && !capture;

    tick_gen #(.CYCLES(DWELL_CYCLES)) u_dwell (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (show && i_auto),
        .i_clr  (capture || advance || !i_auto),
        .o_tick (dwell_tick)
    );

    tick_gen #(.CYCLES(SCAN_CYCLES)) u_scan (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (show),
        .i_clr  (capture),
        .o_tick (scan_tick)
    );

    always_comb begin
        state_d  = state_q;
        digest_d = digest_q;
        idx_d    = idx_q;
        select_d = select_q;
        wrap_d   = 1'b0;
        ready_d  = 1'b1;

        if (capture) begin
            state_d  = SHOW;
            digest_d = i_digest;
            idx_d    = '0;
            select_d = '0;
        end else begin
            if (advance) begin
                wrap_d = (idx_q == IDX_W'(NUM_WORDS - 1));
                idx_d  = wrap_d ? '0 : idx_q + 1'b1;
            end
            if (scan_tick) begin
                select_d = select_q + 1'b1;
            end
        end

        // Word is looked up from next-state values so it is valid right after capture.
        busy_d = (state_d == SHOW);
        word_d = busy_d ? digest_word(digest_d, idx_d) : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            digest_q <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            select_q <= '0;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            digest_q <= digest_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            select_q <= select_d;
            wrap_q   <= wrap_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign o_digest_ready = ready_q;
    assign o_word         = word_q;
    assign o_select       = select_q;
    assign o_word_idx     = idx_q;
    assign o_busy         = busy_q;
    assign o_wrap         = wrap_q;

endmodule

// File: tb/tb_digest_word_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of the sequencer's rules.
module tb_digest_word_sequencer;

    localparam int DWELL = 4;
    localparam int SCAN  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         ready;
    logic [159:0] digest = '0;
    logic         step = 1'b0;
    logic         auto_en = 1'b0;
    logic [31:0]  word;
    logic [2:0]   sel;
    logic [2:0]   idx;
    logic         busy;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    digest_word_sequencer #(
        .DWELL_CYCLES (DWELL),
        .SCAN_CYCLES  (SCAN)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_digest_valid (valid),
        .o_digest_ready (ready),
        .i_digest       (digest),
        .i_step         (step),
        .i_auto         (auto_en),
        .o_word         (word),
        .o_select       (sel),
        .o_word_idx     (idx),
        .o_busy         (busy),
        .o_wrap         (wrap)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_words [5];
    int  m_idx, m_dwell, m_scan, m_sel;
    bit  m_show, m_ready, m_wrap;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) m_words[k] = '0;
        m_idx = 0; m_dwell = 0; m_scan = 0; m_sel = 0;
        m_show = 0; m_ready = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        bit cap, adv;
        cap = valid && m_ready;
        adv = m_show && (step || (auto_en && m_dwell == DWELL - 1));
        m_wrap = 0;
        if (cap) begin
            for (int k = 0; k < 5; k++) m_words[k] = digest[(4 - k) * 32 +: 32];
            m_idx = 0; m_dwell = 0; m_scan = 0; m_sel = 0; m_show = 1;
            $display("capture H0=%h H4=%h at %0t", m_words[0], m_words[4], $time);
        end else if (m_show) begin
            if (adv) begin
                m_wrap = (m_idx == 4);
                m_idx  = (m_idx + 1) % 5;
            end
            m_dwell = (!auto_en || adv) ? 0 : m_dwell + 1;
            m_scan++;
            if (m_scan == SCAN) begin
                m_scan = 0;
                m_sel  = (m_sel + 1) % 8;
            end
        end
        m_ready = 1;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".word"},  word,  m_show ? m_words[m_idx] : 32'h0);
        check_val({tag, ".sel"},   32'(sel),   32'(m_sel));
        check_val({tag, ".idx"},   32'(idx),   32'(m_idx));
        check_val({tag, ".busy"},  32'(busy),  32'(m_show));
        check_val({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
        check_val({tag, ".ready"}, 32'(ready), 32'(m_ready));
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    localparam logic [159:0] ABC  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D012 = {5{32'h01234567}};

    logic [31:0] abc_seq [6];
    int  prev_idx;
    bit  found;

    initial begin
        abc_seq[0] = 32'ha9993e36; abc_seq[1] = 32'h4706816a; abc_seq[2] = 32'hba3e2571;
        abc_seq[3] = 32'h7850c26c; abc_seq[4] = 32'h9cd0d89d; abc_seq[5] = 32'ha9993e36;
        model_reset();

        // Reset held: everything zero, ready low even with valid asserted
        valid = 1'b1; digest = ABC;
        @(posedge clk); #1;
        check_outputs("reset_hold");
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("ready_before_edge", 32'(ready), 32'd0);
        cycle("ready_rise");
        check_val("ready_first_edge", 32'(ready), 32'd1);

        // Capture SHA-1("abc")
        valid = 1'b1; digest = ABC;
        cycle("capture_abc");
        valid = 1'b0;
        check_val("abc_word0", word, 32'ha9993e36);
        check_val("abc_busy", 32'(busy), 32'd1);
        check_val("abc_idx", 32'(idx), 32'd0);

        // Five manual steps with idle gaps
        for (int s = 1; s <= 5; s++) begin
            step = 1'b1;
            cycle("step");
            step = 1'b0;
            check_val("step_word", word, abc_seq[s]);
            check_val("step_wrap", 32'(wrap), (s == 5) ? 32'd1 : 32'd0);
            cycle("step_gap");
            cycle("step_gap");
        end

        // Auto advance, then a step landing on the dwell tick
        auto_en = 1'b1;
        for (int c = 0; c < 14; c++) cycle("auto");
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (m_show && m_dwell == DWELL - 1) begin
                found = 1;
                prev_idx = m_idx;
                step = 1'b1;
                cycle("step_tick");
                step = 1'b0;
                check_val("step_tick_single", 32'(idx), 32'((prev_idx + 1) % 5));
            end else begin
                cycle("seek_tick");
            end
        end
        check_val("step_tick_found", 32'(found), 32'd1);
        auto_en = 1'b0;

        // Scan sweep across a full 0..7,0 cycle, then capture mid-scan
        for (int c = 0; c < 26; c++) cycle("scan");
        valid = 1'b1; digest = ABC;
        cycle("capture_midscan");
        valid = 1'b0;
        check_val("midscan_sel", 32'(sel), 32'd0);

        // Reach index 3, then capture together with a step
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; cycle("to_idx3"); step = 1'b0;
        end
        check_val("at_idx3", 32'(idx), 32'd3);
        valid = 1'b1; digest = D012; step = 1'b1;
        cycle("capture_with_step");
        valid = 1'b0; step = 1'b0;
        check_val("cws_idx", 32'(idx), 32'd0);
        check_val("cws_word", word, 32'h01234567);
        check_val("cws_wrap", 32'(wrap), 32'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            valid   = ($urandom_range(0, 19) == 0);
            step    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 29) == 0) auto_en = ~auto_en;
            digest  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            cycle("rand");
        end
        valid = 1'b0; step = 1'b0; auto_en = 1'b0;

        // Asynchronous reset between edges while in SHOW
        valid = 1'b1; digest = ABC;
        cycle("pre_async");
        valid = 1'b0;
        cycle("pre_async2");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk); #1;
        check_outputs("async_rst_hold");
        #2;
        rst = 1'b0;
        #1;
        check_val("async_ready_low", 32'(ready), 32'd0);
        step = 1'b1;
        cycle("post_rst");
        step = 1'b0;
        check_val("post_rst_ready", 32'(ready), 32'd1);
        check_val("post_rst_busy", 32'(busy), 32'd0);
        cycle("post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
